dac_spi_driver: RTL and testbench



---
 rtl/dac_spi_driver_pkg.sv | 34 +++
 rtl/dac_sclk_div.sv | 47 ++++
 rtl/dac_spi_driver.sv | 181 ++++++++++++++++++
 tb/tb_dac_spi_driver.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_spi_driver_pkg.sv
// Shared definitions for the DAC serial link.
// Holds the driver state encoding, the frame width, the DAC word field
// positions and a helper that assembles a DAC word from channel and code,
// so the wave controller and the SPI driver agree on the word layout.
package dac_spi_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_GAP   = 2'b11
  } dac_state_e;

  localparam int DAC_FRAME_W   = 16;
  localparam int DAC_CH_MSB    = 15;
  localparam int DAC_CH_LSB    = 14;
  localparam int DAC_ZERO_MSB  = 13;
  localparam int DAC_ZERO_LSB  = 12;
  localparam int DAC_CODE_MSB  = 11;
  localparam int DAC_CODE_LSB  = 0;
  localparam int DAC_BIT_CNT_W = 4;
  localparam int DAC_DIV_CNT_W = 8;

  // Build a DAC word: channel in the top field, zero pad, 12-bit code.
  function automatic logic [DAC_FRAME_W-1:0] dac_make_word(input logic [1:0]  ch,
                                                           input logic [11:0] code);
    logic [DAC_FRAME_W-1:0] w;
    w = {DAC_FRAME_W{1'b0}};
    w[DAC_CH_MSB:DAC_CH_LSB]     = ch;
    w[DAC_CODE_MSB:DAC_CODE_LSB] = code;
    return w;
  endfunction

endpackage

// File: rtl/dac_sclk_div.sv
// SCLK half-period timer for the DAC SPI driver.
// While en is high, counts CLK_DIV cycles per SCLK half-period, starting in
// the high half. fall_tick is high in the last cycle of a high half and
// rise_tick in the last cycle of a low half, so the owner registers the new
// SCLK level on that edge. Dropping en returns the timer to the start of a
// high half.
// Ports: clk, rst_n (async active-low), en, rise_tick, fall_tick.
module dac_sclk_div
  import dac_spi_driver_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic rise_tick,
  output logic fall_tick
);

  localparam logic [DAC_DIV_CNT_W-1:0] DIV_LAST = DAC_DIV_CNT_W'(CLK_DIV - 1);

  logic [DAC_DIV_CNT_W-1:0] cnt_r;
  logic                     low_r;   // 1 while in the low half-period

  // Half-period counter; held at the start of a high half when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {DAC_DIV_CNT_W{1'b0}};
      low_r <= 1'b0;
    end else if (!en) begin
      cnt_r <= {DAC_DIV_CNT_W{1'b0}};
      low_r <= 1'b0;
    end else if (cnt_r == DIV_LAST) begin
      cnt_r <= {DAC_DIV_CNT_W{1'b0}};
      low_r <= ~low_r;
    end else begin
      cnt_r <= cnt_r + {{(DAC_DIV_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Tick decode from the counter state.
  always_comb begin
    fall_tick = en && !low_r && (cnt_r == DIV_LAST);
    rise_tick = en &&  low_r && (cnt_r == DIV_LAST);
  end

endmodule

// File: rtl/dac_spi_driver.sv
// SPI driver for a 16-bit serial DAC.
// Accepts DAC words on a one-cycle DataValid strobe, shifts them out MSB
// first with SCLK idling high (DAC samples on SCLK fall), frames each word
// with DAC_SYNC_n low and keeps a one-word pending slot for words that arrive
// while a frame is running. Every output is a register.
// Ports: CLK, RST_n (async active-low), DataIn[15:0], DataValid,
//        DAC_SCLK, DAC_SYNC_n, DAC_DIN, BusySgn, Ready, Done, Overrun.
module dac_spi_driver
  import dac_spi_driver_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int GAP_CYC = 2
) (
  input  logic                   CLK,
  input  logic                   RST_n,
  input  logic [DAC_FRAME_W-1:0] DataIn,
  input  logic                   DataValid,
  output logic                   DAC_SCLK,
  output logic                   DAC_SYNC_n,
  output logic                   DAC_DIN,
  output logic                   BusySgn,
  output logic                   Ready,
  output logic                   Done,
  output logic                   Overrun
);

  localparam logic [DAC_DIV_CNT_W-1:0] GAP_LAST = DAC_DIV_CNT_W'(GAP_CYC - 1);
  localparam logic [DAC_BIT_CNT_W-1:0] BIT_LAST = DAC_BIT_CNT_W'(DAC_FRAME_W - 1);

  dac_state_e               state_r;
  logic [DAC_FRAME_W-2:0]   shift_r;      // bits still to send after DAC_DIN
  logic [DAC_FRAME_W-1:0]   slot_r;
  logic                     slot_full_r;
  logic [DAC_BIT_CNT_W-1:0] bit_cnt_r;
  logic [DAC_DIV_CNT_W-1:0] gap_cnt_r;
  logic                     sclk_r;
  logic                     sync_n_r;
  logic                     din_r;
  logic                     busy_r;
  logic                     ready_r;
  logic                     done_r;
  logic                     overrun_r;

  logic                     shift_en_s;
  logic                     rise_tick_s;
  logic                     fall_tick_s;
  logic                     slot_wr_s;
  logic                     overrun_s;
  logic                     slot_full_s;
  logic [DAC_FRAME_W-1:0]   slot_s;

  // SCLK timing runs only while a frame is being shifted.
  always_comb begin
    shift_en_s = (state_r == ST_SHIFT);
  end

  dac_sclk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_div (
    .clk       (CLK),
    .rst_n     (RST_n),
    .en        (shift_en_s),
    .rise_tick (rise_tick_s),
    .fall_tick (fall_tick_s)
  );

  // Pending-slot update. In IDLE a word goes straight to the shifter; in
  // LOAD the slot is being emptied this cycle, so a write refills it
  // without counting as an overwrite.
  always_comb begin
    slot_wr_s = DataValid && (state_r != ST_IDLE);
    overrun_s = slot_wr_s && slot_full_r && (state_r != ST_LOAD);
    slot_s    = slot_wr_s ? DataIn : slot_r;
    if (state_r == ST_LOAD) begin
      slot_full_s = slot_wr_s;
    end else begin
      slot_full_s = slot_full_r || slot_wr_s;
    end
  end

  // Driver FSM with shifter, counters and registered outputs.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_r     <= ST_IDLE;
      shift_r     <= {(DAC_FRAME_W-1){1'b0}};
      slot_r      <= {DAC_FRAME_W{1'b0}};
      slot_full_r <= 1'b0;
      bit_cnt_r   <= {DAC_BIT_CNT_W{1'b0}};
      gap_cnt_r   <= {DAC_DIV_CNT_W{1'b0}};
      sclk_r      <= 1'b1;
      sync_n_r    <= 1'b1;
      din_r       <= 1'b0;
      busy_r      <= 1'b0;
      ready_r     <= 1'b1;
      done_r      <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      done_r      <= 1'b0;
      overrun_r   <= overrun_s;
      slot_r      <= slot_s;
      slot_full_r <= slot_full_s;
      ready_r     <= ~slot_full_s;
      case (state_r)
        ST_IDLE: begin
          if (DataValid) begin
            din_r     <= DataIn[DAC_FRAME_W-1];
            shift_r   <= DataIn[DAC_FRAME_W-2:0];
            sync_n_r  <= 1'b0;
            sclk_r    <= 1'b1;
            bit_cnt_r <= {DAC_BIT_CNT_W{1'b0}};
            busy_r    <= 1'b1;
            state_r   <= ST_SHIFT;
          end else begin
            busy_r    <= 1'b0;
          end
        end
        ST_LOAD: begin
          din_r     <= slot_r[DAC_FRAME_W-1];
          shift_r   <= slot_r[DAC_FRAME_W-2:0];
          sync_n_r  <= 1'b0;
          sclk_r    <= 1'b1;
          bit_cnt_r <= {DAC_BIT_CNT_W{1'b0}};
          busy_r    <= 1'b1;
          state_r   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (fall_tick_s) begin
            sclk_r <= 1'b0;
          end else if (rise_tick_s) begin
            sclk_r <= 1'b1;
            if (bit_cnt_r == BIT_LAST) begin
              // Last bit sampled: close the frame on this SCLK rise.
              sync_n_r  <= 1'b1;
              din_r     <= 1'b0;
              done_r    <= 1'b1;
              bit_cnt_r <= {DAC_BIT_CNT_W{1'b0}};
              gap_cnt_r <= {DAC_DIV_CNT_W{1'b0}};
              state_r   <= ST_GAP;
            end else begin
              din_r     <= shift_r[DAC_FRAME_W-2];
              shift_r   <= {shift_r[DAC_FRAME_W-3:0], 1'b0};
              bit_cnt_r <= bit_cnt_r + {{(DAC_BIT_CNT_W-1){1'b0}}, 1'b1};
            end
          end else begin
            sclk_r <= sclk_r;
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            gap_cnt_r <= {DAC_DIV_CNT_W{1'b0}};
            // A word landing in this very cycle still counts as pending.
            if (slot_full_s) begin
              state_r <= ST_LOAD;
            end else begin
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end
          end else begin
            gap_cnt_r <= gap_cnt_r + {{(DAC_DIV_CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          sclk_r   <= 1'b1;
          sync_n_r <= 1'b1;
          din_r    <= 1'b0;
          busy_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign DAC_SCLK   = sclk_r;
  assign DAC_SYNC_n = sync_n_r;
  assign DAC_DIN    = din_r;
  assign BusySgn    = busy_r;
  assign Ready      = ready_r;
  assign Done       = done_r;
  assign Overrun    = overrun_r;

endmodule

// File: tb/tb_dac_spi_driver.sv
// Directed bench for dac_spi_driver: one instance with CLK_DIV=2/GAP_CYC=2
// and one with CLK_DIV=1. Monitors decode the DAC pins on the falling CLK
// edge; directed vectors are compared against hand-computed values.
module tb_dac_spi_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data;
  logic        dv;
  logic        sclk, sync_n, din, busy, ready, done, ovr;
  logic [15:0] data1;
  logic        dv1;
  logic        sclk1, sync_n1, din1, busy1, ready1, done1, ovr1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dac_spi_driver #(.CLK_DIV(2), .GAP_CYC(2)) dut (
    .CLK(clk), .RST_n(rst_n), .DataIn(data), .DataValid(dv),
    .DAC_SCLK(sclk), .DAC_SYNC_n(sync_n), .DAC_DIN(din),
    .BusySgn(busy), .Ready(ready), .Done(done), .Overrun(ovr)
  );

  dac_spi_driver #(.CLK_DIV(1), .GAP_CYC(2)) dut1 (
    .CLK(clk), .RST_n(rst_n), .DataIn(data1), .DataValid(dv1),
    .DAC_SCLK(sclk1), .DAC_SYNC_n(sync_n1), .DAC_DIN(din1),
    .BusySgn(busy1), .Ready(ready1), .Done(done1), .Overrun(ovr1)
  );

  // Monitor state for the CLK_DIV=2 instance.
  logic [15:0] frames[$];
  logic [15:0] rx_sh = 16'h0000;
  int rx_bits = 0, low_run = 0, high_run = 0, last_low_run = 0, last_high_run = 0;
  int sclk_edges = 0, ovr_cnt = 0, done_cnt = 0;
  logic prev_sclk = 1'b1, prev_sync = 1'b1;

  // Decode frames, SYNC_n run lengths and pulse counts of the main instance.
  always @(negedge clk) begin
    if (sclk != prev_sclk) sclk_edges++;
    if (prev_sync && !sync_n) begin
      last_high_run = high_run; rx_bits = 0; low_run = 0;
    end
    if (!prev_sync && sync_n) begin
      last_low_run = low_run; high_run = 0;
      if (rx_bits == 16) frames.push_back(rx_sh);
    end
    if (prev_sclk && !sclk && !sync_n) begin
      rx_sh = {rx_sh[14:0], din}; rx_bits++;
    end
    if (sync_n) high_run++; else low_run++;
    if (ovr)  ovr_cnt++;
    if (done) done_cnt++;
    prev_sclk = sclk; prev_sync = sync_n;
  end

  // Monitor state for the CLK_DIV=1 instance.
  logic [15:0] rx_sh1 = 16'h0000, last_word1 = 16'h0000;
  int low_run1 = 0, last_low_run1 = 0, falls1 = 0, din_bad1 = 0;
  logic prev_sclk1 = 1'b1, prev_sync1 = 1'b1;

  // Decode the CLK_DIV=1 instance: low-run length, falls, DIN stability.
  always @(negedge clk) begin
    if (prev_sync1 && !sync_n1) begin low_run1 = 0; falls1 = 0; end
    if (!prev_sync1 && sync_n1) begin last_low_run1 = low_run1; last_word1 = rx_sh1; end
    if (prev_sclk1 && !sclk1 && !sync_n1) begin rx_sh1 = {rx_sh1[14:0], din1}; falls1++; end
    if (!sync_n1) begin low_run1++; if (din1 !== 1'b1) din_bad1++; end
    prev_sclk1 = sclk1; prev_sync1 = sync_n1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w);
    data = w; dv = 1'b1;
    @(posedge clk); #1;
    dv = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || !sync_n) && n < 600) begin
      @(posedge clk); #1; n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  function automatic logic [31:0] frame_at(input int idx);
    if (idx < frames.size()) return {16'h0000, frames[idx]};
    else return 32'hDEAD_BEEF;
  endfunction

  int base, o0, d0, snap_edges, snap_fr, n1;

  initial begin
    rst_n = 1'b0; dv = 1'b0; data = 16'h0000; dv1 = 1'b0; data1 = 16'h0000;
    tick(3);
    check("rst_sclk",   {31'd0, sclk},   32'd1);
    check("rst_sync_n", {31'd0, sync_n}, 32'd1);
    check("rst_din",    {31'd0, din},    32'd0);
    check("rst_busy",   {31'd0, busy},   32'd0);
    check("rst_ready",  {31'd0, ready},  32'd1);
    check("rst_done",   {31'd0, done},   32'd0);
    check("rst_ovr",    {31'd0, ovr},    32'd0);
    rst_n = 1'b1;
    tick(3);

    // Single frame 47FF: 64 low cycles, Done on cycle 65, IDLE on cycle 67.
    base = frames.size(); d0 = done_cnt; o0 = ovr_cnt;
    send(16'h47FF);
    check("f1_sync_c1", {31'd0, sync_n}, 32'd0);
    check("f1_busy_c1", {31'd0, busy},   32'd1);
    check("f1_sclk_c1", {31'd0, sclk},   32'd1);
    tick(63);
    check("f1_sync_c64", {31'd0, sync_n}, 32'd0);
    tick(1);
    check("f1_sync_c65", {31'd0, sync_n}, 32'd1);
    check("f1_done_c65", {31'd0, done},   32'd1);
    tick(1);
    check("f1_done_c66", {31'd0, done}, 32'd0);
    check("f1_busy_c66", {31'd0, busy}, 32'd1);
    tick(1);
    check("f1_busy_c67", {31'd0, busy}, 32'd0);
    check("f1_word", frame_at(base), 32'h0000_47FF);
    check("f1_low_run", last_low_run, 32'd64);
    check("f1_done_cnt", done_cnt - d0, 32'd1);

    // Back-to-back 8123 / 8456, second issued 10 cycles after the first.
    base = frames.size(); o0 = ovr_cnt;
    send(16'h8123);
    check("b2b_din_msb", {31'd0, din}, 32'd1);
    tick(9);
    check("b2b_ready_before", {31'd0, ready}, 32'd1);
    send(16'h8456);
    check("b2b_ready_low", {31'd0, ready}, 32'd0);
    tick(59);
    check("b2b_sync_c70",  {31'd0, sync_n}, 32'd0);
    check("b2b_ready_c70", {31'd0, ready},  32'd1);
    wait_idle("b2b_idle");
    check("b2b_word0", frame_at(base),     32'h0000_8123);
    check("b2b_word1", frame_at(base + 1), 32'h0000_8456);
    check("b2b_gap",   last_high_run,      32'd3);
    check("b2b_ovr",   ovr_cnt - o0,       32'd0);

    // Three words in one frame: C002 is overwritten by C003.
    base = frames.size(); o0 = ovr_cnt;
    send(16'hC001);
    tick(5);
    send(16'hC002);
    check("ovr_first_write", {31'd0, ovr}, 32'd0);
    tick(5);
    send(16'hC003);
    check("ovr_pulse", {31'd0, ovr}, 32'd1);
    tick(1);
    check("ovr_one_cycle", {31'd0, ovr}, 32'd0);
    wait_idle("ovr_idle");
    check("ovr_word0", frame_at(base),     32'h0000_C001);
    check("ovr_word1", frame_at(base + 1), 32'h0000_C003);
    check("ovr_frames", frames.size() - base, 32'd2);
    check("ovr_cnt",   ovr_cnt - o0,       32'd1);

    // Write during the LOAD cycle (cycle 67) refills the slot quietly.
    base = frames.size(); o0 = ovr_cnt;
    send(16'h2AAA);
    tick(9);
    send(16'h3555);
    tick(56);
    check("ld_sync_c67", {31'd0, sync_n}, 32'd1);
    send(16'h0F0F);
    check("ld_ovr",     {31'd0, ovr},    32'd0);
    check("ld_ready",   {31'd0, ready},  32'd0);
    check("ld_sync_c68",{31'd0, sync_n}, 32'd0);
    wait_idle("ld_idle");
    check("ld_word0", frame_at(base),     32'h0000_2AAA);
    check("ld_word1", frame_at(base + 1), 32'h0000_3555);
    check("ld_word2", frame_at(base + 2), 32'h0000_0F0F);
    check("ld_ovr_cnt", ovr_cnt - o0,     32'd0);

    // Write in the last GAP cycle (cycle 66) with the slot empty.
    base = frames.size();
    send(16'h9111);
    tick(65);
    check("lg_busy_c66", {31'd0, busy}, 32'd1);
    send(16'h6222);
    check("lg_ready_c67", {31'd0, ready},  32'd0);
    check("lg_sync_c67",  {31'd0, sync_n}, 32'd1);
    tick(1);
    check("lg_sync_c68",  {31'd0, sync_n}, 32'd0);
    wait_idle("lg_idle");
    check("lg_word0", frame_at(base),     32'h0000_9111);
    check("lg_word1", frame_at(base + 1), 32'h0000_6222);
    check("lg_gap",   last_high_run,      32'd3);

    // Reset at frame cycle 20 (bit 11, SCLK low, DIN high).
    send(16'hFFFF);
    tick(19);
    check("rs_sclk_pre", {31'd0, sclk}, 32'd0);
    check("rs_din_pre",  {31'd0, din},  32'd1);
    rst_n = 1'b0;
    #1;
    check("rs_sync",  {31'd0, sync_n}, 32'd1);
    check("rs_sclk",  {31'd0, sclk},   32'd1);
    check("rs_din",   {31'd0, din},    32'd0);
    check("rs_busy",  {31'd0, busy},   32'd0);
    check("rs_ready", {31'd0, ready},  32'd1);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    snap_edges = sclk_edges; snap_fr = frames.size();
    tick(30);
    check("rs_no_edges",  sclk_edges,    snap_edges);
    check("rs_no_frame",  frames.size(), snap_fr);
    check("rs_sync_idle", {31'd0, sync_n}, 32'd1);

    // CLK_DIV=1 instance, all-ones word.
    data1 = 16'hFFFF; dv1 = 1'b1;
    @(posedge clk); #1;
    dv1 = 1'b0;
    n1 = 0;
    while ((busy1 || !sync_n1) && n1 < 200) begin @(posedge clk); #1; n1++; end
    tick(2);
    check("d1_idle",    {31'd0, busy1}, 32'd0);
    check("d1_low_run", last_low_run1,  32'd32);
    check("d1_falls",   falls1,         32'd16);
    check("d1_din_bad", din_bad1,       32'd0);
    check("d1_word",    {16'h0000, last_word1}, 32'h0000_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
